// File: rtl/jtag_scan_master.sv
// jtag_scan_master: command-driven JTAG master sequencing TLR, IR/DR scans and idle TCKs with TDO capture
module jtag_scan_master #(
  parameter int TCK_DIV = 5,
  parameter int IR_LEN  = 4,
  parameter int DR_MAX  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [5:0]        cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              rsp_err,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic              TRST_n
);
  typedef enum logic [3:0] {IDLE, TLR, SEL_DR, SEL_IR, CAPTURE, SHIFT, UPDATE, RTI, RESP} state_t;
  localparam int CW = $clog2(TCK_DIV);
  localparam logic [CW-1:0] DIV_TOP = CW'(TCK_DIV - 1);
  state_t state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [5:0] bit_q, bit_d, len_q, len_d;
  logic [1:0] op_q, op_d;
  logic [DR_MAX-1:0] data_q, data_d, mask_q, mask_d, rdata_q, rdata_d;
  logic tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, err_q, err_d, trst_q;
  logic active, wrap, rise, fall, last, bad;
  assign active = !(state_q inside {IDLE, RESP});
  assign wrap = div_q == DIV_TOP;
  assign rise = active && !tck_q && wrap;
  assign fall = active && tck_q && wrap;
  assign bad = (cmd_op == 2'd2 && (cmd_len == '0 || int'(cmd_len) > DR_MAX)) || (cmd_op == 2'd3 && cmd_len == '0);
  // CAPTURE spans two TCKs: Select->Capture and Capture->Shift
  assign last = state_q == TLR ? bit_q == 6'd5 :
                state_q == CAPTURE ? bit_q == 6'd1 :
                (state_q == SHIFT || (state_q == RTI && op_q == 2'd3)) ? bit_q == len_q - 6'd1 : 1'b1;
  always_comb begin
    state_d = state_q;
    div_d = active ? (wrap ? '0 : div_q + 1'b1) : '0;
    tck_d = active && (wrap ? !tck_q : tck_q);
    bit_d = bit_q;
    len_d = len_q;
    op_d = op_q;
    data_d = data_q;
    mask_d = mask_q;
    rdata_d = rdata_q;
    err_d = err_q;
    if (state_q == IDLE && cmd_valid) begin
      op_d = cmd_op;
      len_d = cmd_op == 2'd1 ? 6'(IR_LEN) : cmd_len;
      data_d = cmd_data;
      mask_d = {{(DR_MAX-1){1'b0}}, 1'b1};
      rdata_d = '0;
      err_d = bad;
      bit_d = '0;
      state_d = bad ? RESP : cmd_op == 2'd0 ? TLR : cmd_op == 2'd3 ? RTI : SEL_DR;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
    end else if (rise && state_q == SHIFT && TDO) begin
      rdata_d = rdata_q | mask_q;
    end else if (fall) begin
      bit_d = last ? '0 : bit_q + 6'd1;
      if (state_q == SHIFT) begin
        data_d = data_q >> 1;
        mask_d = mask_q << 1;
      end
      state_d = !last ? state_q :
                (state_q == TLR || state_q == RTI) ? RESP :
                state_q == SEL_DR ? (op_q == 2'd1 ? SEL_IR : CAPTURE) :
                state_q == SEL_IR ? CAPTURE :
                state_q == CAPTURE ? SHIFT :
                state_q == SHIFT ? UPDATE : RTI;
    end
    tms_d = state_d == TLR ? bit_d != 6'd5 :
            state_d == SHIFT ? bit_d == len_d - 6'd1 :
            !(state_d inside {CAPTURE, RTI});
    tdi_d = state_d == SHIFT && data_d[0];
  end
  always_ff @(posedge clk) begin
    trst_q <= !rst;
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      bit_q <= '0;
      len_q <= '0;
      op_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      tck_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      len_q <= len_d;
      op_q <= op_d;
      data_q <= data_d;
      mask_q <= mask_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      tck_q <= tck_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rdata_q;
  assign rsp_err = err_q;
  assign TCK = tck_q;
  assign TMS = tms_q;
  assign TDI = tdi_q;
  assign TRST_n = trst_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: table-driven scoreboard bench driving a behavioural 4-bit-IR TAP
module tb_jtag_scan_master;
  localparam int DIV = 5;
  localparam int NV = 21;
  localparam logic [31:0] IDCODE = 32'h1CAFE0BF;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_len = '0;
  logic [31:0] cmd_data = '0, rsp_data;
  logic cmd_ready, rsp_valid, rsp_err, TCK, TMS, TDI, TDO, TRST_n;
  int tests = 0, fails = 0, rises = 0;
  always #5 clk = ~clk;
  jtag_scan_master #(.TCK_DIV(DIV), .IR_LEN(4), .DR_MAX(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TRST_n(TRST_n)
  );
  typedef enum int {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_t;
  function automatic tap_t nxt(input tap_t s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      T_UIR:  return m ? T_SDR  : T_RTI;
      default: return T_TLR;
    endcase
  endfunction
  // TAP: IR 1 = IDCODE, IR 8 = 32-bit user register, anything else = bypass
  tap_t tap_st = T_TLR;
  logic [31:0] dr_sr = '0, ureg = '0;
  logic [3:0] ir_sr = '0, ir = 4'h1;
  logic tdo_q = 1'b0;
  assign TDO = tdo_q;
  always @(posedge TCK or negedge TRST_n)
    if (!TRST_n) tap_st <= T_TLR;
    else begin
      case (tap_st)
        T_CDR:  dr_sr <= ir == 4'h1 ? IDCODE : ir == 4'h8 ? ureg : 32'h0;
        T_SHDR: dr_sr <= (ir == 4'h1 || ir == 4'h8) ? {TDI, dr_sr[31:1]} : {31'h0, TDI};
        T_CIR:  ir_sr <= 4'b0101;
        T_SHIR: ir_sr <= {TDI, ir_sr[3:1]};
        default: ;
      endcase
      tap_st <= nxt(tap_st, TMS);
    end
  always @(negedge TCK or negedge TRST_n)
    if (!TRST_n) begin
      ir <= 4'h1;
      ureg <= '0;
      tdo_q <= 1'b0;
    end else begin
      tdo_q <= tap_st == T_SHDR ? dr_sr[0] : tap_st == T_SHIR ? ir_sr[0] : 1'b0;
      if (tap_st == T_TLR) begin
        ir <= 4'h1;
        ureg <= '0;
      end
      if (tap_st == T_UIR) ir <= ir_sr;
      if (tap_st == T_UDR && ir == 4'h8) ureg <= dr_sr;
    end
  always @(posedge TCK) rises++;
  // pin-timing monitor: half-period lengths, TMS/TDI moving only on TCK falls, TCK parked when idle
  int half_bad = 0, half_n = 0, tms_bad = 0, tms_n = 0, idle_bad = 0, run = 0;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0, p_rdy = 1'b1;
  always @(negedge clk) begin
    if (cmd_ready && TCK) idle_bad++;
    if (rst || cmd_ready) run = 0;
    else if (TCK == p_tck) run++;
    else begin
      half_n++;
      if (run != DIV) half_bad++;
      run = 1;
    end
    if (!rst && !cmd_ready && !p_rdy && (TMS != p_tms || TDI != p_tdi)) begin
      tms_n++;
      if (!(p_tck && !TCK)) tms_bad++;
    end
    p_tck = TCK;
    p_tms = TMS;
    p_tdi = TDI;
    p_rdy = cmd_ready;
  end
  typedef struct {
    logic [1:0] op;
    logic [5:0] len;
    logic [31:0] data;
    logic [31:0] exp;
    logic err;
    int tcks;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic e;
  } exp_t;
  vec_t vt [NV];
  exp_t sb [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int n;
    n = 0;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = ~op;
    cmd_len = ~len;
    cmd_data = ~data;
  endtask
  task automatic recv(input string name, output int lat);
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({name, "_valid"}, rsp_valid, 1);
    chk({name, "_data"}, rsp_data, e.d);
    chk({name, "_err"}, {31'h0, rsp_err}, {31'h0, e.e});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int r0, lat, n;
    vt[0]  = '{2'd0, 6'd0,  32'h0,        32'h0,        1'b0, 6};
    vt[1]  = '{2'd2, 6'd32, 32'h0,        IDCODE,       1'b0, 37};
    vt[2]  = '{2'd1, 6'd0,  32'h8,        32'h5,        1'b0, 10};
    vt[3]  = '{2'd2, 6'd32, 32'hA5A55A5A, 32'h0,        1'b0, 37};
    vt[4]  = '{2'd2, 6'd32, 32'h0,        32'hA5A55A5A, 1'b0, 37};
    vt[5]  = '{2'd2, 6'd16, 32'hFFFF1234, 32'h0,        1'b0, 21};
    vt[6]  = '{2'd2, 6'd32, 32'hFFFFFFFF, 32'h12340000, 1'b0, 37};
    vt[7]  = '{2'd2, 6'd8,  32'h0,        32'h000000FF, 1'b0, 13};
    vt[8]  = '{2'd2, 6'd1,  32'h0,        32'h00000001, 1'b0, 6};
    vt[9]  = '{2'd3, 6'd3,  32'h0000FFFF, 32'h0,        1'b0, 3};
    vt[10] = '{2'd2, 6'd0,  32'hFFFFFFFF, 32'h0,        1'b1, 0};
    vt[11] = '{2'd2, 6'd40, 32'hFFFFFFFF, 32'h0,        1'b1, 0};
    vt[12] = '{2'd3, 6'd0,  32'hFFFFFFFF, 32'h0,        1'b1, 0};
    vt[13] = '{2'd2, 6'd33, 32'hFFFFFFFF, 32'h0,        1'b1, 0};
    vt[14] = '{2'd2, 6'd32, 32'hDEADBEEF, 32'h007FFFFF, 1'b0, 37};
    vt[15] = '{2'd1, 6'd0,  32'h1,        32'h5,        1'b0, 10};
    vt[16] = '{2'd2, 6'd32, 32'h0,        IDCODE,       1'b0, 37};
    vt[17] = '{2'd1, 6'd0,  32'hF,        32'h5,        1'b0, 10};
    vt[18] = '{2'd2, 6'd4,  32'hA,        32'h4,        1'b0, 9};
    vt[19] = '{2'd3, 6'd63, 32'h0,        32'h0,        1'b0, 63};
    vt[20] = '{2'd0, 6'd0,  32'h0,        32'h0,        1'b0, 6};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", TCK, 0);
    chk("rst_tms", TMS, 1);
    chk("rst_tdi", TDI, 0);
    chk("rst_trst_n", TRST_n, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("trst_n_release", TRST_n, 1);
    for (int i = 0; i < NV; i++) begin
      r0 = rises;
      sb.push_back('{vt[i].exp, vt[i].err});
      send(vt[i].op, vt[i].len, vt[i].data);
      recv($sformatf("v%0d", i), lat);
      chk($sformatf("v%0d_tck_rises", i), rises - r0, vt[i].tcks);
      chk($sformatf("v%0d_tap_in_rti", i), tap_st == T_RTI, 1);
      if (vt[i].err) chk($sformatf("v%0d_err_latency", i), lat, 0);
    end
    rsp_ready = 1'b0;
    sb.push_back('{IDCODE, 1'b0});
    send(2'd2, 6'd32, 32'h0);
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmd_op = 2'd0;
    cmd_len = 6'd0;
    cmd_valid = 1'b1;
    r0 = rises;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_ready_err", {29'h0, rsp_valid, cmd_ready, rsp_err}, 32'h4);
      chk("bp_data_stable", rsp_data, IDCODE);
    end
    recv("bp", lat);
    chk("bp_ready_after_handshake", cmd_ready, 1);
    chk("bp_no_early_accept", rises - r0, 0);
    sb.push_back('{32'h0, 1'b0});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("bp_pending_accepted", cmd_ready, 0);
    recv("bp_next", lat);
    chk("bp_next_tck_rises", rises - r0, 6);
    r0 = rises;
    send(2'd2, 6'd32, 32'h0);
    n = 0;
    while (rises - r0 < 14 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reach_bit10", rises - r0, 14);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tck", TCK, 0);
    chk("mid_rst_tms", TMS, 1);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    chk("mid_rst_trst_n", TRST_n, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_trst_n_release", TRST_n, 1);
    sb.push_back('{32'h0, 1'b0});
    send(2'd0, 6'd0, 32'h0);
    recv("post_rst_tlr", lat);
    sb.push_back('{IDCODE, 1'b0});
    send(2'd2, 6'd32, 32'h0);
    recv("post_rst_idcode", lat);
    chk("tck_half_period_errors", half_bad, 0);
    chk("tck_edges_observed", half_n > 100, 1);
    chk("tms_tdi_off_fall_errors", tms_bad, 0);
    chk("tms_tdi_changes_observed", tms_n > 10, 1);
    chk("tck_high_while_ready", idle_bad, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
